axi_simple_master: RTL and testbench
====================================

# axi_simple_master

Single-outstanding AXI4 initiator that turns a simple valid/ready word-access request port into single-beat AXI read or write transactions and returns one response per request. It sits between a local requester (boot loader, debug/DMA engine, test harness) and the AXI interconnect, driving `s_axi_mosi_t` and receiving `s_axi_miso_t` from `utils_pkg`. It is the initiator counterpart of the on-chip AXI responders (boot ROM, RAM wrappers).

## Interface
- `AXI_ID`, default `'0`: `axi_tid_t` value driven on `awid`/`arid` and expected on `bid`/`rid`.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when `req_valid_i && req_ready_o`.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  32  byte address, passed unmodified.
- `req_wdata_i`  in  32  write data.
- `req_wstrb_i`  in  4  write byte strobes.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumed when `rsp_valid_o && rsp_ready_i`.
- `rsp_rdata_o`  out  32  read data; 0 for writes.
- `rsp_err_o`  out  1  transaction error.
- `axi_mosi`  out  `s_axi_mosi_t`  AXI initiator outputs.
- `axi_miso`  in  `s_axi_miso_t`  AXI responder outputs.

## Operation
- States: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, RSP. Reset state IDLE.
- IDLE: `req_ready_o`=1. On accept, latch addr/we/wdata/wstrb; go WR if `req_we_i` else RD_ADDR.
- WR: `awvalid` and `wvalid` both asserted on entry; each drops independently after its own handshake (`aw_done`, `w_done` flags); AW and W handshakes may occur in either order or the same cycle. When both done -> WR_RESP.
- WR_RESP: `bready`=1. On `bvalid`: `rsp_err_o` latched = (`bresp`!=OKAY) or (`bid`!=`AXI_ID`); `rsp_rdata_o`=0; -> RSP.
- RD_ADDR: `arvalid`=1 until `arready` -> RD_DATA.
- RD_DATA: `rready`=1. On `rvalid`: latch `rdata`; err = (`rresp`!=OKAY) or (`rlast`==0) or (`rid`!=`AXI_ID`); -> RSP.
- RSP: `rsp_valid_o`=1, data/err stable until `rsp_ready_i`, then -> IDLE.
- Fixed AXI fields: `awlen`/`arlen`=0, `awsize`/`arsize`=3'b010, `awburst`/`arburst`=INCR, `wlast`=1, lock/cache/prot/qos/region/user=0. Address/data/strobes driven from latched registers, never from `req_*` directly.
- `bvalid`/`rvalid` outside WR_RESP/RD_DATA are ignored (`bready`/`rready`=0).
- Write with `req_wstrb_i`=0 is still issued.

## Timing
- Reset (async assert): state IDLE, all AXI valids/readies 0, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, `req_ready_o`=1 once in IDLE. Any in-flight transaction is abandoned; no response produced.
- All AXI valid/ready outputs and `rsp_*` are registered or pure state decodes; no combinational path from `axi_miso` or `rsp_ready_i` to any output.
- Read, zero-wait responder (`arready`=1, `rvalid` cycle after AR): accept at N, `arvalid` N+1, `rvalid` N+2, `rsp_valid_o` N+3. Next request accepted earliest cycle after `rsp_ready_i`.
- Write, `awready`=`wready`=1, `bvalid` cycle after: accept N, AW/W N+1, `bvalid` N+2, `rsp_valid_o` N+3.
- Valids, once high, stay high with stable payload until handshake (AXI rule).
- Throughput: one transaction at a time; `req_ready_o`=0 outside IDLE.

## Test plan
- Read from zero-wait ROM model returning 0xDEADBEEF, rid=`AXI_ID`, rlast=1 -> `rsp_valid_o` at N+3, rdata 0xDEADBEEF, err 0; `arlen`=0, `arsize`=2.
- Write addr 0x100, data 0xA5A5_5A5A, wstrb 4'b0011; responder delays `awready` 3 cycles, `wready` 0 -> W first, AW later, single `bvalid` OKAY -> rsp err 0, rdata 0, exactly one AW and one W beat.
- Read with rresp=SLVERR, then read with rlast=0, then write with bid!=`AXI_ID` -> `rsp_err_o`=1 each time.
- `rsp_ready_i` held low 5 cycles in RSP -> rsp payload stable, `req_ready_o`=0, new `req_valid_i` not accepted until after consume.
- Spurious `rvalid`/`bvalid` in IDLE -> ignored, no response; `rready`/`bready` stay 0.
- `rst` asserted while `arvalid` high waiting for `arready` -> `arvalid` drops immediately, IDLE, no `rsp_valid_o`; next read after release completes normally.

Source files
------------

// File: rtl/axi_simple_master.sv
// Single-outstanding AXI4 initiator: maps a valid/ready word-access port onto
// single-beat AXI reads/writes and returns exactly one response per request.
package utils_pkg;
  typedef logic [3:0] axi_tid_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef struct packed {
    axi_tid_t    awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  awqos;
    logic [3:0]  awregion;
    logic        awuser;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wuser;
    logic        wvalid;
    logic        bready;
    axi_tid_t    arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic [3:0]  arregion;
    logic        aruser;
    logic        arvalid;
    logic        rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    axi_tid_t    bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    axi_tid_t    rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
  } s_axi_miso_t;
endpackage

module axi_simple_master #(
  parameter utils_pkg::axi_tid_t AXI_ID = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [31:0]            req_addr_i,
  input  logic [31:0]            req_wdata_i,
  input  logic [3:0]             req_wstrb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [31:0]            rsp_rdata_o,
  output logic                   rsp_err_o,
  output utils_pkg::s_axi_mosi_t axi_mosi,
  input  utils_pkg::s_axi_miso_t axi_miso
);
  import utils_pkg::*;

  // state   | meaning
  // IDLE    | ready for a request
  // WR      | AW and W outstanding, each retires on its own handshake
  // WR_RESP | waiting for B
  // RD_ADDR | AR outstanding
  // RD_DATA | waiting for R
  // RSP     | response held until consumed
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        aw_fin, w_fin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Each write channel is finished once its handshake has happened, now or earlier.
  assign aw_fin = aw_done_q || axi_miso.awready;
  assign w_fin  = w_done_q || axi_miso.wready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d    = req_addr_i;
          wdata_d   = req_wdata_i;
          wstrb_d   = req_wstrb_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_we_i ? WR : RD_ADDR;
        end
      end
      WR: begin
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (axi_miso.bvalid) begin
          rdata_d = '0;
          err_d   = (axi_miso.bresp != AXI_RESP_OKAY) || (axi_miso.bid != AXI_ID);
          state_d = RSP;
        end
      end
      RD_ADDR: begin
        if (axi_miso.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (axi_miso.rvalid) begin
          rdata_d = axi_miso.rdata;
          err_d   = (axi_miso.rresp != AXI_RESP_OKAY) || !axi_miso.rlast ||
                    (axi_miso.rid != AXI_ID);
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    axi_mosi         = '0;
    axi_mosi.awid    = AXI_ID;
    axi_mosi.awaddr  = addr_q;
    axi_mosi.awsize  = 3'b010;
    axi_mosi.awburst = AXI_BURST_INCR;
    axi_mosi.awvalid = (state_q == WR) && !aw_done_q;
    axi_mosi.wdata   = wdata_q;
    axi_mosi.wstrb   = wstrb_q;
    axi_mosi.wlast   = 1'b1;
    axi_mosi.wvalid  = (state_q == WR) && !w_done_q;
    axi_mosi.bready  = (state_q == WR_RESP);
    axi_mosi.arid    = AXI_ID;
    axi_mosi.araddr  = addr_q;
    axi_mosi.arsize  = 3'b010;
    axi_mosi.arburst = AXI_BURST_INCR;
    axi_mosi.arvalid = (state_q == RD_ADDR);
    axi_mosi.rready  = (state_q == RD_DATA);
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RSP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
endmodule

// File: tb/tb_axi_simple_master.sv
// Directed bench for axi_simple_master: the bench plays the AXI responder and
// checks responses against a queue of expected {err, rdata} pushed per request.
module tb_axi_simple_master;
  import utils_pkg::*;

  localparam axi_tid_t TB_ID  = 4'h5;
  localparam axi_tid_t BAD_ID = 4'h9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso = '0;

  int          n_checks = 0;
  int          n_err = 0;
  logic [32:0] sb_q[$];

  always #5 clk = ~clk;

  axi_simple_master #(.AXI_ID(TB_ID)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_wstrb_i (req_wstrb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .axi_mosi    (mosi),
    .axi_miso    (miso)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic collect_rsp(input int hold);
    logic [32:0] exp;
    exp = '0;
    chk("rsp_valid_latency", rsp_valid, 1);
    n_checks++;
    assert (sb_q.size() != 0) else begin
      n_err++;
      $error("FAIL sb_underflow: observed response with %0d expected entries", sb_q.size());
    end
    if (sb_q.size() != 0) exp = sb_q.pop_front();
    chk("rsp_rdata", rsp_rdata, exp[31:0]);
    chk("rsp_err", rsp_err, {31'b0, exp[32]});
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h0000_BAD0;
      tick();
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, exp[31:0]);
      chk("hold_rsp_err", rsp_err, {31'b0, exp[32]});
      chk("hold_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_arvalid", mosi.arvalid, 0);
    chk("post_awvalid", mosi.awvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                         input logic last, input axi_tid_t id, input logic exp_err, input int hold);
    sb_q.push_back({exp_err, data});
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = addr;
    chk("rd_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    chk("rd_arvalid", mosi.arvalid, 1);
    chk("rd_araddr", mosi.araddr, addr);
    chk("rd_arlen", {24'b0, mosi.arlen}, 0);
    chk("rd_arsize", {29'b0, mosi.arsize}, 2);
    chk("rd_arid", {28'b0, mosi.arid}, {28'b0, TB_ID});
    chk("rd_busy_ready", req_ready, 0);
    miso.arready = 1'b1;
    tick();
    miso.arready = 1'b0;
    chk("rd_arvalid_drop", mosi.arvalid, 0);
    chk("rd_rready", mosi.rready, 1);
    miso.rvalid = 1'b1;
    miso.rdata  = data;
    miso.rresp  = resp;
    miso.rlast  = last;
    miso.rid    = id;
    tick();
    miso.rvalid = 1'b0;
    miso.rdata  = $urandom;
    miso.rlast  = 1'b0;
    miso.rresp  = 2'b11;
    collect_rsp(hold);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input axi_tid_t id,
                          input logic [1:0] resp, input logic exp_err);
    int aw_n;
    int w_n;
    int cyc;
    aw_n = 0;
    w_n  = 0;
    cyc  = 0;
    sb_q.push_back({exp_err, 32'h0});
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    req_wstrb = strb;
    chk("wr_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = ~strb;
    while ((aw_n == 0 || w_n == 0) && cyc < 20) begin
      miso.awready = (cyc >= aw_dly);
      miso.wready  = (cyc >= w_dly);
      chk("wr_awvalid_hold", mosi.awvalid, aw_n == 0);
      chk("wr_wvalid_hold", mosi.wvalid, w_n == 0);
      if (mosi.awvalid && miso.awready) begin
        aw_n++;
        chk("wr_awaddr", mosi.awaddr, addr);
        chk("wr_awlen", {24'b0, mosi.awlen}, 0);
        chk("wr_awsize", {29'b0, mosi.awsize}, 2);
        chk("wr_awburst", {30'b0, mosi.awburst}, 1);
      end
      if (mosi.wvalid && miso.wready) begin
        w_n++;
        chk("wr_wdata", mosi.wdata, data);
        chk("wr_wstrb", {28'b0, mosi.wstrb}, {28'b0, strb});
        chk("wr_wlast", mosi.wlast, 1);
      end
      tick();
      cyc++;
    end
    miso.awready = 1'b0;
    miso.wready  = 1'b0;
    chk("wr_aw_beats", aw_n, 1);
    chk("wr_w_beats", w_n, 1);
    chk("wr_awvalid_drop", mosi.awvalid, 0);
    chk("wr_wvalid_drop", mosi.wvalid, 0);
    chk("wr_bready", mosi.bready, 1);
    miso.bvalid = 1'b1;
    miso.bid    = id;
    miso.bresp  = resp;
    tick();
    miso.bvalid = 1'b0;
    miso.bresp  = 2'b11;
    collect_rsp(0);
  endtask

  initial begin
    #1;
    chk("rst_arvalid", mosi.arvalid, 0);
    chk("rst_awvalid", mosi.awvalid, 0);
    chk("rst_wvalid", mosi.wvalid, 0);
    chk("rst_rready", mosi.rready, 0);
    chk("rst_bready", mosi.bready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_req_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();

    // zero-wait ROM read, then writes that must report rdata 0
    do_read(32'h0000_0040, 32'hDEAD_BEEF, AXI_RESP_OKAY, 1'b1, TB_ID, 1'b0, 0);
    do_write(32'h0000_0100, 32'hA5A5_5A5A, 4'b0011, 3, 0, TB_ID, AXI_RESP_OKAY, 1'b0);
    do_write(32'h0000_0104, 32'h1234_5678, 4'b1111, 0, 0, TB_ID, AXI_RESP_OKAY, 1'b0);
    do_write(32'h0000_0108, 32'hCAFE_F00D, 4'b0000, 0, 2, TB_ID, AXI_RESP_OKAY, 1'b0);

    // error responses
    do_read(32'h0000_0200, 32'h1111_2222, AXI_RESP_SLVERR, 1'b1, TB_ID, 1'b1, 0);
    do_read(32'h0000_0204, 32'h3333_4444, AXI_RESP_OKAY, 1'b0, TB_ID, 1'b1, 0);
    do_read(32'h0000_0208, 32'h5555_6666, AXI_RESP_OKAY, 1'b1, BAD_ID, 1'b1, 0);
    do_write(32'h0000_020C, 32'h7777_8888, 4'b1000, 1, 1, BAD_ID, AXI_RESP_OKAY, 1'b1);
    do_write(32'h0000_0210, 32'h9999_AAAA, 4'b0100, 0, 0, TB_ID, AXI_RESP_SLVERR, 1'b1);

    // response backpressure for 5 cycles with a competing request
    do_read(32'h0000_0300, 32'h0BAD_CAFE, AXI_RESP_OKAY, 1'b1, TB_ID, 1'b0, 5);

    // spurious R/B while idle
    miso.rvalid = 1'b1;
    miso.bvalid = 1'b1;
    miso.rlast  = 1'b1;
    miso.rid    = TB_ID;
    miso.bid    = TB_ID;
    miso.rresp  = AXI_RESP_OKAY;
    miso.bresp  = AXI_RESP_OKAY;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spur_rready", mosi.rready, 0);
      chk("spur_bready", mosi.bready, 0);
      chk("spur_rsp_valid", rsp_valid, 0);
      chk("spur_req_ready", req_ready, 1);
    end
    miso.rvalid = 1'b0;
    miso.bvalid = 1'b0;

    // reset while AR is stalled
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_0400;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_arvalid", mosi.arvalid, 1);
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    chk("arst_arvalid", mosi.arvalid, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rready", mosi.rready, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_arvalid", mosi.arvalid, 0);
    do_read(32'h0000_0404, 32'hFEED_FACE, AXI_RESP_OKAY, 1'b1, TB_ID, 1'b0, 0);

    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
